ps2_device_transmitter: RTL
===========================

# ps2_device_transmitter

Device-side PS/2 transmitter that sends bytes to a host PS/2 port over the open-drain PS2_CLK/PS2_DAT pair, generating the PS/2 clock itself. It is the opposite end of the system's PS/2 host ports and is used to emulate a keyboard or mouse on a GPIO header, both for loop-back testing of the ps2_port controllers and for board-to-board links. It accepts bytes through a valid/ready handshake, frames each byte, detects host inhibit and retransmits aborted frames.

## Interface
- CLK_HALF, default 2000: PS/2 clock half-period in clk cycles (40 µs at 50 MHz, 12.5 kHz bus clock); minimum 8.
- IDLE_CYCLES, default 2500: consecutive cycles both lines must read high before a frame starts (50 µs).
- SETTLE, default 4: cycles after releasing PS2_CLK before inhibit sampling starts.
- clk, input, 1: single clock. All state changes on the rising edge.
- reset, input, 1: synchronous, active-high.
- in_data, input, 8: byte to transmit.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block accepts a byte this cycle.
- ps2_clk_in, input, 1: raw PS2_CLK pad level (asynchronous).
- ps2_dat_in, input, 1: raw PS2_DAT pad level (asynchronous).
- ps2_clk_oe, output, 1: 1 = drive PS2_CLK low, 0 = release.
- ps2_dat_oe, output, 1: 1 = drive PS2_DAT low, 0 = release.
- busy, output, 1: a byte is held (accepted, not yet completed).
- done, output, 1: one-cycle pulse when a frame completes.
- aborted, output, 1: one-cycle pulse on each host-inhibit abort.
- host_request, output, 1: synchronized PS2_DAT low while PS2_CLK high, sampled only in IDLE and WAIT_BUS.

## Operation
- ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer. All line decisions use the synchronized values.
- The frame is 11 bits, bit index 0..10:
  - 0 = start bit (0).
  - 1..8 = in_data, LSB first.
  - 9 = odd parity, equal to ~^data.
  - 10 = stop bit (1).
- A line is driven low when its bit is 0. A 1 is produced by releasing the line (oe=0), never by driving it.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch the byte, set busy=1 and go to WAIT_BUS.
  - WAIT_BUS: both oe=0. The idle counter increments while the synchronized clk and dat are both 1 and clears otherwise. When it reaches IDLE_CYCLES, set idx=0 and go to BIT_HIGH.
  - BIT_HIGH: clk_oe=0 and dat_oe=~bit[idx], held for CLK_HALF cycles. From cycle SETTLE onward, a synchronized clk=0 means host inhibit: raise the aborted pulse, release both lines and go to WAIT_BUS with the byte retained. If the phase completes, go to BIT_LOW.
  - BIT_LOW: clk_oe=1 and dat_oe unchanged, held for CLK_HALF cycles; the host samples on this falling edge. At the end, if idx<10, increment idx and go to BIT_HIGH; if idx==10, go to TAIL.
  - TAIL: both oe=0 for CLK_HALF cycles. Then pulse done, clear busy and go to IDLE. Inhibit during TAIL is ignored because the frame is already complete.
- Retries are unlimited. The byte is never dropped except by reset.
- There is no host-to-device receive. host_request is status only, and WAIT_BUS waits it out because dat is low.

## Timing
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, in_ready=0, busy=0, done=0, aborted=0, host_request=0, state IDLE.
- in_ready rises on the first clock after reset deasserts.
- All outputs are registered.
- Accept on edge N gives in_ready=0 and busy=1 from N+1.
- With an idle bus, the first BIT_HIGH (ps2_dat_oe=1) begins 2 (synchronizer) + IDLE_CYCLES cycles after acceptance, ±1.
- Frame timing from BIT_HIGH entry:
  - 22·CLK_HALF cycles to the end of the last BIT_LOW.
  - Plus CLK_HALF for TAIL.
  - Then done, with in_ready=1 on the same edge.
- A byte presented while done pulses is accepted one cycle later at the earliest.
- The first falling PS2_CLK edge follows data setup by exactly CLK_HALF cycles.
- Reset mid-frame releases both lines on the next edge and discards the byte.
- in_valid while busy is ignored, because in_ready=0.

## Test plan
- Reset, CLK_HALF=8, IDLE_CYCLES=16, send 0x1C → a host model sampling on PS2_CLK falling edges reads start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1; there are 11 falling edges; done pulses once; in_ready returns to 1.
- Send 0x00, then 0xFF back-to-back with in_valid held → parity 1 then parity 1; two done pulses; the frames are separated by at least IDLE_CYCLES of idle bus.
- Host pulls PS2_CLK low during BIT_HIGH of idx 5 for 100 cycles → aborted pulses once; both oe go to 0; after release plus IDLE_CYCLES the full frame is resent from the start bit; there is a single done.
- Host holds PS2_DAT low in IDLE, then a byte is offered → host_request=1, the transmitter stays in WAIT_BUS (no clk_oe) until DAT is released, then transmits.
- Host pulls PS2_CLK low during TAIL → no abort; done pulses; no retransmission.
- Assert reset during BIT_LOW of idx 3 → the next edge gives clk_oe=0, dat_oe=0, busy=0; after reset no frame resumes.

Source files
------------

// File: rtl/ps2_device_transmitter.sv
// Device-side PS/2 transmitter: frames bytes (start, 8 data LSB first, odd
// parity, stop), drives the open-drain PS2_CLK/PS2_DAT lines itself, and
// retransmits the whole frame whenever the host inhibits mid-frame.
module ps2_device_transmitter #(
    parameter int CLK_HALF    = 2000,
    parameter int IDLE_CYCLES = 2500,
    parameter int SETTLE      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       host_request
);

    localparam int CNT_MAX = (CLK_HALF > IDLE_CYCLES) ? CLK_HALF : IDLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_BIT_HIGH,
        ST_BIT_LOW,
        ST_TAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic          in_ready_q, in_ready_d, busy_q, busy_d;
    logic          done_q, done_d, aborted_q, aborted_d;
    logic          host_request_q, host_request_d;
    logic [10:0]   frame;

    // Frame bit i is what the line carries in bit slot i (0 = drive low).
    assign frame = {1'b1, ~^data_q, data_q, 1'b0};

    assign in_ready     = in_ready_q;
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_dat_oe   = dat_oe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign host_request = host_request_q;

    // State register, synchronizers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            data_q         <= '0;
            clk_meta_q     <= 1'b1;
            clk_sync_q     <= 1'b1;
            dat_meta_q     <= 1'b1;
            dat_sync_q     <= 1'b1;
            clk_oe_q       <= 1'b0;
            dat_oe_q       <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            host_request_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            clk_meta_q     <= clk_meta_d;
            clk_sync_q     <= clk_sync_d;
            dat_meta_q     <= dat_meta_d;
            dat_sync_q     <= dat_sync_d;
            clk_oe_q       <= clk_oe_d;
            dat_oe_q       <= dat_oe_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
            host_request_q <= host_request_d;
        end
    end

    // Next-state logic; line enables are computed for the state being entered
    // so every pad output comes straight from a flop.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        data_d         = data_q;
        clk_meta_d     = ps2_clk_in;
        clk_sync_d     = clk_meta_q;
        dat_meta_d     = ps2_dat_in;
        dat_sync_d     = dat_meta_q;
        clk_oe_d       = clk_oe_q;
        dat_oe_d       = dat_oe_q;
        in_ready_d     = in_ready_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        aborted_d      = 1'b0;
        host_request_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d       = 1'b0;
                dat_oe_d       = 1'b0;
                in_ready_d     = 1'b1;
                host_request_d = clk_sync_q & ~dat_sync_q;
                if (in_valid && in_ready_q) begin
                    data_d     = in_data;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_WAIT_BUS;
                end
            end
            ST_WAIT_BUS: begin
                clk_oe_d       = 1'b0;
                dat_oe_d       = 1'b0;
                host_request_d = clk_sync_q & ~dat_sync_q;
                if (clk_sync_q && dat_sync_q) begin
                    if (cnt_q == CW'(IDLE_CYCLES)) begin
                        cnt_d    = '0;
                        idx_d    = '0;
                        dat_oe_d = ~frame[0];
                        state_d  = ST_BIT_HIGH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_BIT_HIGH: begin
                // The first SETTLE cycles are skipped because the synchronizer
                // still shows our own low clock after release.
                if (cnt_q >= CW'(SETTLE) && !clk_sync_q) begin
                    aborted_d = 1'b1;
                    clk_oe_d  = 1'b0;
                    dat_oe_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_BUS;
                end else if (cnt_q == CW'(CLK_HALF - 1)) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = ST_BIT_LOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BIT_LOW: begin
                if (cnt_q == CW'(CLK_HALF - 1)) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    if (idx_q == 4'd10) begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_TAIL;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        dat_oe_d = ~frame[idx_q + 4'd1];
                        state_d  = ST_BIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_TAIL: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (cnt_q == CW'(CLK_HALF - 1)) begin
                    cnt_d      = '0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule
